// File: rtl/sigma_mem_ctl.sv
// Handshaked, byte-lane main memory bank for the Sigma CPU with programmable wait states.
// Define MEM_PARITY_EN to store and check one odd-parity bit per byte lane.
module sigma_mem_ctl #(
   parameter int    ADDR_WIDTH  = 17,
   parameter int    LANES       = 4,
   parameter int    DEPTH       = 128,
   parameter int    WAIT_STATES = 0,
   parameter string INIT_FILE   = ""
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       req,
   input  logic                       wr,
   input  logic [32-ADDR_WIDTH:31]    address,
   input  logic [0:LANES-1]           write_en,
   input  logic [0:8*LANES-1]         data_in,
   output logic                       busy,
   output logic                       ready,
   output logic [0:8*LANES-1]         data_out,
   output logic                       error
);

   localparam int DATA_W = 8 * LANES;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [1:0]            state;
   logic [3:0]            cnt;
   logic                  err_q;

   logic                  wr_p0;
   logic [ADDR_WIDTH-1:0] addr_p0;
   logic [0:LANES-1]      we_p0;
   logic [0:DATA_W-1]     din_p0;

   logic                  cm_wr;
   logic [ADDR_WIDTH-1:0] cm_addr;
   logic [0:LANES-1]      cm_we;
   logic [0:DATA_W-1]     cm_din;

   logic                  accept;
   logic                  commit;
   logic                  in_range;
   logic [IDX_W-1:0]      idx;
   logic [0:DATA_W-1]     rd_word;
   logic                  par_bad;

   logic [0:DATA_W-1]     mem [DEPTH];

   function automatic logic [0:LANES-1] odd_par(input logic [0:DATA_W-1] w);
      logic [0:LANES-1] p;
      for (int i = 0; i < LANES; i++) p[i] = ~^w[8*i +: 8];
      return p;
   endfunction

   assign accept = req && (state != S_WAIT);
   assign commit = (accept && (WAIT_STATES == 0)) || ((state == S_WAIT) && (cnt == 4'd0));

   // With zero wait states the commit edge is also the accept edge, so operands come straight from the ports.
   always_comb begin
      cm_wr   = wr_p0;
      cm_addr = addr_p0;
      cm_we   = we_p0;
      cm_din  = din_p0;
      if (accept) begin
         cm_wr   = wr;
         cm_addr = address;
         cm_we   = write_en;
         cm_din  = data_in;
      end
   end

   assign in_range = {1'b0, cm_addr} < (ADDR_WIDTH + 1)'(DEPTH);
   assign idx      = cm_addr[IDX_W-1:0];
   assign rd_word  = mem[idx];

`ifdef MEM_PARITY_EN
   logic [0:LANES-1] par [DEPTH];

   assign par_bad = |(par[idx] ^ odd_par(rd_word));

   always_ff @(posedge clock) begin
      if (reset && commit && cm_wr && in_range) begin
         for (int i = 0; i < LANES; i++)
            if (cm_we[i]) par[idx][i] <= ~^cm_din[8*i +: 8];
      end
   end
`else
   assign par_bad = 1'b0;
`endif

   // Storage survives reset; only an access committing outside reset may touch it.
   always_ff @(posedge clock) begin
      if (reset && commit && cm_wr && in_range) begin
         for (int i = 0; i < LANES; i++)
            if (cm_we[i]) mem[idx][8*i +: 8] <= cm_din[8*i +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         wr_p0   <= wr;
         addr_p0 <= address;
         we_p0   <= write_en;
         din_p0  <= data_in;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         err_q    <= 1'b0;
         data_out <= '0;
      end else begin
         case (state)
            S_WAIT: begin
               if (cnt == 4'd0) state <= S_RESP;
               else             cnt   <= cnt - 4'd1;
            end
            default: begin
               if (req) begin
                  if (WAIT_STATES == 0) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_LOAD;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
         if (commit) begin
            err_q <= !in_range || (!cm_wr && par_bad);
            if (!cm_wr) data_out <= in_range ? rd_word : '0;
         end
      end
   end

   assign busy  = (state == S_WAIT);
   assign ready = (state == S_RESP);
   assign error = (state == S_RESP) && err_q;

endmodule
